contador_regressivo_m: RTL and testbench
========================================

# contador_regressivo_m

Programmable down-counter/timer with start/cancel control and a one-cycle expiry pulse. It loads a runtime value, decrements on each `conta` enable, and flags expiry at zero, with optional auto-reload. It is the counting-down counterpart of the modulo-M up-counter. Datapaths use it for timeouts and for per-play/per-round time limits driven by a control-unit FSM.

## Interface
- `M`, 3000: maximum load value. Larger loads saturate to M.
- `N`, 12: counter width. Requires M < 2^N.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `zera_s`  in  1  synchronous active-high reset; only reset, no asynchronous clear.
- `iniciar`  in  1  start/restart: load `carga` and begin counting.
- `cancelar`  in  1  abort: return to idle, Q cleared.
- `conta`  in  1  count enable/tick; decrement when counting.
- `recarga_auto`  in  1  when 1, expiry reloads the last load value and keeps counting.
- `carga`  in  N  initial count value.
- `Q`  out  N  current count (registered).
- `fim`  out  1  registered one-cycle expiry pulse.
- `meio`  out  1  combinational half-time flag.
- `ocupado`  out  1  high while in CONTANDO.
- `expirou`  out  1  high while in EXPIRADO.
- `estado`  out  2  FSM state encoding: OCIOSO=00, CONTANDO=01, EXPIRADO=10.

## Operation
- Registered state: FSM state, Q, `limite` (the saturated load value), `fim`.
- Reset values (after a `zera_s` edge):
  - state OCIOSO, Q=0, limite=0, fim=0.
  - Therefore meio=0, ocupado=0, expirou=0.
- Input priority, every cycle: `zera_s` > `cancelar` > `iniciar` > `conta`.
- Load value: carga_sat = (carga > M) ? M : carga.
- `iniciar` in any state:
  - Q <= carga_sat and limite <= carga_sat.
  - If carga_sat == 0: next state EXPIRADO and fim <= 1.
  - Otherwise: next state CONTANDO.
  - `conta` is ignored in the load cycle.
- OCIOSO: holds Q. `conta` is ignored.
- CONTANDO, with `conta`=1:
  - If Q > 1: Q <= Q-1.
  - If Q == 1 and recarga_auto=0: Q <= 0, fim <= 1, next state EXPIRADO.
  - If Q == 1 and recarga_auto=1: Q <= limite, fim <= 1, stay in CONTANDO.
  - With `conta`=0: hold.
- EXPIRADO:
  - Q holds 0 and `conta` is ignored.
  - Leaves only via `iniciar` (reload) or `cancelar` (to OCIOSO).
- `cancelar` in any state: Q <= 0, next state OCIOSO, fim <= 0. This holds even if the same cycle would have expired.
- `fim` is 0 in every cycle where it is not explicitly set above, so it is never high for two consecutive cycles unless expiries are consecutive.
- `meio` = (state == CONTANDO) && (limite >= 2) && (Q == limite >> 1).
- No underflow: Q never wraps below 0.

## Timing
- Load latency: 1 cycle. The `iniciar` edge makes Q=carga_sat visible on the next cycle.
- With `conta` held high after the start edge, load K ≥ 1:
  - Q reaches 0 and `fim`=1 together, K edges after the start edge.
  - `fim` drops 1 cycle later.
- In auto-reload with K ≥ 1 and `conta` held high, expiry pulses repeat every K cycles.
- `fim`, `Q`, `estado`, `ocupado` and `expirou` are registered, or decoded from registered state only. `meio` is decoded from registers, so it is glitch-free at the sampling edge.
- Simultaneous events:
  - `iniciar` and `conta` in the same cycle: load only, no decrement.
  - `cancelar` and `iniciar`: cancel wins.
  - `zera_s` mid-count: all outputs reach their reset values on that edge, and `fim` is not emitted.
- `iniciar` held high restarts every cycle, so Q stays at carga_sat and no decrement occurs.

## Test plan
- Reset then start: `zera_s` pulse, then `iniciar` with carga=5 and `conta`=1 held.
  - Q sequence is 5,4,3,2,1,0.
  - fim=1 only in the Q=0 cycle, then expirou=1 and estado=10.
  - meio=1 only when Q=2.
- Saturation and zero load:
  - carga=4000 (M=3000) loads Q=3000.
  - carga=0 goes directly to EXPIRADO with a single fim pulse, and ocupado never rises.
- Auto-reload: carga=3, recarga_auto=1, conta=1.
  - Q follows 3,2,1,3,2,1,...
  - fim pulses on each 1→3 transition, one cycle wide, every 3 cycles. estado stays 01.
- Gated count and cancel: carga=4 with `conta` toggling 1,0,1,0.
  - Q decrements only on enabled cycles.
  - `cancelar` at Q=2 gives Q=0 and OCIOSO next cycle, with no fim.
- Simultaneous events and mid-run reset:
  - `cancelar`+`iniciar` in the same cycle gives OCIOSO.
  - `iniciar`+`conta` loads without a decrement.
  - `zera_s` at Q=1 with `conta`=1 gives all outputs reset and fim=0.

Source files
------------

// File: rtl/contador_regressivo_m.sv
// contador_regressivo_m
// Programmable down-counter/timer. A start loads a (saturated) count value,
// each `conta` tick decrements it, and reaching zero raises a one-cycle
// `fim` pulse. With `recarga_auto` set, expiry reloads the last load value
// and counting continues instead of parking in EXPIRADO.
//
// Ports:
//   clock        system clock, rising edge
//   zera_s       synchronous active-high reset
//   iniciar      load `carga` (saturated to M) and start counting
//   cancelar     abort to OCIOSO with Q cleared
//   conta        count tick, honoured only in CONTANDO
//   recarga_auto reload on expiry instead of stopping
//   carga        load value
//   Q            current count (registered)
//   fim          one-cycle expiry pulse (registered)
//   meio         half-time flag, decoded from registers
//   ocupado      high in CONTANDO
//   expirou      high in EXPIRADO
//   estado       state encoding
//
// state    | meaning
// OCIOSO   | idle, Q held (0 after reset/cancel), ticks ignored
// CONTANDO | counting down on each `conta`
// EXPIRADO | reached zero without auto-reload, waits for start or cancel
module contador_regressivo_m #(
    parameter int M = 3000,
    parameter int N = 12
) (
    input  logic         clock,
    input  logic         zera_s,
    input  logic         iniciar,
    input  logic         cancelar,
    input  logic         conta,
    input  logic         recarga_auto,
    input  logic [N-1:0] carga,
    output logic [N-1:0] Q,
    output logic         fim,
    output logic         meio,
    output logic         ocupado,
    output logic         expirou,
    output logic [1:0]   estado
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'b00,
        CONTANDO = 2'b01,
        EXPIRADO = 2'b10
    } estado_t;

    localparam logic [N-1:0] M_MAX = N'(M);
    localparam logic [N-1:0] UM    = N'(1);
    localparam logic [N-1:0] DOIS  = N'(2);

    estado_t      estado_r;
    logic [N-1:0] limite;
    logic [N-1:0] carga_sat;

    assign carga_sat = (carga > M_MAX) ? M_MAX : carga;

    always_ff @(posedge clock) begin
        if (zera_s) begin
            estado_r <= OCIOSO;
            Q        <= '0;
            limite   <= '0;
            fim      <= 1'b0;
        end else begin
            // fim is a pulse: cleared unless an expiry sets it this cycle.
            fim <= 1'b0;
            if (cancelar) begin
                estado_r <= OCIOSO;
                Q        <= '0;
            end else if (iniciar) begin
                Q      <= carga_sat;
                limite <= carga_sat;
                if (carga_sat == '0) begin
                    estado_r <= EXPIRADO;
                    fim      <= 1'b1;
                end else begin
                    estado_r <= CONTANDO;
                end
            end else begin
                case (estado_r)
                    CONTANDO: begin
                        if (conta) begin
                            if (Q > UM) begin
                                Q <= Q - UM;
                            end else if (recarga_auto) begin
                                // limite >= 1 here, since a zero load never enters CONTANDO.
                                Q   <= limite;
                                fim <= 1'b1;
                            end else begin
                                Q        <= '0;
                                fim      <= 1'b1;
                                estado_r <= EXPIRADO;
                            end
                        end
                    end
                    EXPIRADO: begin
                        Q <= '0;
                    end
                    OCIOSO: begin
                        Q <= Q;
                    end
                    default: begin
                        estado_r <= OCIOSO;
                        Q        <= '0;
                    end
                endcase
            end
        end
    end

    assign meio    = (estado_r == CONTANDO) && (limite >= DOIS) && (Q == (limite >> 1));
    assign ocupado = (estado_r == CONTANDO);
    assign expirou = (estado_r == EXPIRADO);
    assign estado  = estado_r;

endmodule

// File: tb/tb_contador_regressivo_m.sv
module tb_contador_regressivo_m;

    localparam int M = 3000;
    localparam int N = 12;

    logic         clock = 1'b0;
    logic         zera_s;
    logic         iniciar;
    logic         cancelar;
    logic         conta;
    logic         recarga_auto;
    logic [N-1:0] carga;
    logic [N-1:0] Q;
    logic         fim;
    logic         meio;
    logic         ocupado;
    logic         expirou;
    logic [1:0]   estado;

    int checks = 0;
    int errors = 0;

    contador_regressivo_m #(.M(M), .N(N)) dut (
        .clock        (clock),
        .zera_s       (zera_s),
        .iniciar      (iniciar),
        .cancelar     (cancelar),
        .conta        (conta),
        .recarga_auto (recarga_auto),
        .carga        (carga),
        .Q            (Q),
        .fim          (fim),
        .meio         (meio),
        .ocupado      (ocupado),
        .expirou      (expirou),
        .estado       (estado)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int q, input int f, input int m,
                           input int o, input int e, input int st);
        chk({tag, ".Q"},       int'(Q),       q);
        chk({tag, ".fim"},     int'(fim),     f);
        chk({tag, ".meio"},    int'(meio),    m);
        chk({tag, ".ocupado"}, int'(ocupado), o);
        chk({tag, ".expirou"}, int'(expirou), e);
        chk({tag, ".estado"},  int'(estado),  st);
    endtask

    initial begin
        zera_s = 1'b1; iniciar = 1'b0; cancelar = 1'b0; conta = 1'b0;
        recarga_auto = 1'b0; carga = '0;
        step();
        zera_s = 1'b0;
        chk_all("reset", 0, 0, 0, 0, 0, 0);

        // Count 5 down to 0 with conta held high
        carga = 12'd5; iniciar = 1'b1; conta = 1'b1;
        step(); chk_all("c5_load", 5, 0, 0, 1, 0, 1);
        iniciar = 1'b0;
        step(); chk_all("c5_q4", 4, 0, 0, 1, 0, 1);
        step(); chk_all("c5_q3", 3, 0, 0, 1, 0, 1);
        step(); chk_all("c5_q2", 2, 0, 1, 1, 0, 1);
        step(); chk_all("c5_q1", 1, 0, 0, 1, 0, 1);
        step(); chk_all("c5_q0", 0, 1, 0, 0, 1, 2);
        step(); chk_all("c5_after", 0, 0, 0, 0, 1, 2);
        step(); chk_all("c5_hold", 0, 0, 0, 0, 1, 2);

        // Saturating load (restart from EXPIRADO)
        carga = 12'd4000; iniciar = 1'b1; conta = 1'b0;
        step(); chk_all("sat", 3000, 0, 0, 1, 0, 1);

        // Zero load goes straight to EXPIRADO
        carga = 12'd0;
        step(); chk_all("zero_load", 0, 1, 0, 0, 1, 2);
        iniciar = 1'b0;
        step(); chk_all("zero_after", 0, 0, 0, 0, 1, 2);

        // Auto-reload with period 3
        recarga_auto = 1'b1; carga = 12'd3; iniciar = 1'b1; conta = 1'b1;
        step(); chk_all("ar_load", 3, 0, 0, 1, 0, 1);
        iniciar = 1'b0;
        step(); chk_all("ar_q2a", 2, 0, 0, 1, 0, 1);
        step(); chk_all("ar_q1a", 1, 0, 1, 1, 0, 1);
        step(); chk_all("ar_rel1", 3, 1, 0, 1, 0, 1);
        step(); chk_all("ar_q2b", 2, 0, 0, 1, 0, 1);
        step(); chk_all("ar_q1b", 1, 0, 1, 1, 0, 1);
        step(); chk_all("ar_rel2", 3, 1, 0, 1, 0, 1);
        cancelar = 1'b1;
        step(); chk_all("ar_cancel", 0, 0, 0, 0, 0, 0);
        cancelar = 1'b0; recarga_auto = 1'b0;

        // Gated count, iniciar+conta loads without decrement
        carga = 12'd4; iniciar = 1'b1; conta = 1'b1;
        step(); chk_all("g_load", 4, 0, 0, 1, 0, 1);
        iniciar = 1'b0;
        step(); chk_all("g_en1", 3, 0, 0, 1, 0, 1);
        conta = 1'b0;
        step(); chk_all("g_dis1", 3, 0, 0, 1, 0, 1);
        conta = 1'b1;
        step(); chk_all("g_en2", 2, 0, 1, 1, 0, 1);
        conta = 1'b0;
        step(); chk_all("g_dis2", 2, 0, 1, 1, 0, 1);
        cancelar = 1'b1; conta = 1'b1;
        step(); chk_all("g_cancel", 0, 0, 0, 0, 0, 0);
        cancelar = 1'b0;
        step(); chk_all("idle_tick", 0, 0, 0, 0, 0, 0);

        // cancelar beats iniciar
        carga = 12'd7; iniciar = 1'b1; cancelar = 1'b1;
        step(); chk_all("can_ini", 0, 0, 0, 0, 0, 0);

        // cancelar beats an expiry in the same cycle
        carga = 12'd1; cancelar = 1'b0; conta = 1'b0;
        step(); chk_all("one_load", 1, 0, 0, 1, 0, 1);
        iniciar = 1'b0; cancelar = 1'b1; conta = 1'b1;
        step(); chk_all("can_exp", 0, 0, 0, 0, 0, 0);
        cancelar = 1'b0;

        // iniciar held restarts every cycle
        carga = 12'd6; iniciar = 1'b1; conta = 1'b1;
        step(); chk_all("hold_a", 6, 0, 0, 1, 0, 1);
        step(); chk_all("hold_b", 6, 0, 0, 1, 0, 1);
        step(); chk_all("hold_c", 6, 0, 0, 1, 0, 1);

        // Mid-run reset at Q=1 with conta high suppresses fim
        carga = 12'd2;
        step(); chk_all("mr_load", 2, 0, 0, 1, 0, 1);
        iniciar = 1'b0;
        step(); chk_all("mr_q1", 1, 0, 1, 1, 0, 1);
        zera_s = 1'b1;
        step(); chk_all("mr_reset", 0, 0, 0, 0, 0, 0);
        zera_s = 1'b0;
        step(); chk_all("mr_after", 0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
